// File: rtl/reg_access_ctrl.sv
// Two-requester arbiter in front of a register file, with one response slot per requester.
// Ties go to the requester that was not granted last; writes to register 0 are acknowledged but dropped.
module reg_access_ctrl #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          REGCTL_clk,
   input  logic          REGCTL_rst_n,
   // requester A
   input  logic          REGCTL_A_valid,
   output logic          REGCTL_A_ready,
   input  logic          REGCTL_A_we,
   input  logic [AW-1:0] REGCTL_A_addr1,
   input  logic [AW-1:0] REGCTL_A_addr2,
   input  logic [AW-1:0] REGCTL_A_waddr,
   input  logic [DW-1:0] REGCTL_A_wdata,
   output logic          REGCTL_A_rsp_valid,
   input  logic          REGCTL_A_rsp_ready,
   output logic [DW-1:0] REGCTL_A_rsp_data1,
   output logic [DW-1:0] REGCTL_A_rsp_data2,
   // requester B
   input  logic          REGCTL_B_valid,
   output logic          REGCTL_B_ready,
   input  logic          REGCTL_B_we,
   input  logic [AW-1:0] REGCTL_B_addr1,
   input  logic [AW-1:0] REGCTL_B_addr2,
   input  logic [AW-1:0] REGCTL_B_waddr,
   input  logic [DW-1:0] REGCTL_B_wdata,
   output logic          REGCTL_B_rsp_valid,
   input  logic          REGCTL_B_rsp_ready,
   output logic [DW-1:0] REGCTL_B_rsp_data1,
   output logic [DW-1:0] REGCTL_B_rsp_data2,
   // register file
   output logic [AW-1:0] REGCTL_rf_addr1,
   output logic [AW-1:0] REGCTL_rf_addr2,
   output logic [AW-1:0] REGCTL_rf_waddr,
   output logic          REGCTL_rf_we,
   output logic [DW-1:0] REGCTL_rf_wdata,
   input  logic [DW-1:0] REGCTL_rf_rdata1,
   input  logic [DW-1:0] REGCTL_rf_rdata2
);

   typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

   slot_e         a_state_q, a_state_d;
   slot_e         b_state_q, b_state_d;
   logic          last_grant_q, last_grant_d;   // 1 = B granted last
   logic [DW-1:0] a_data1_q, a_data1_d, a_data2_q, a_data2_d;
   logic [DW-1:0] b_data1_q, b_data1_d, b_data2_q, b_data2_d;

   logic          elig_a, elig_b, grant_a, grant_b;
   logic          sel_we;
   logic [DW-1:0] rsp_data1, rsp_data2;

   // Arbitration. Reset gates eligibility so nothing is accepted or written while rst_n=0.
   always_comb begin
      elig_a  = REGCTL_rst_n & REGCTL_A_valid & ((a_state_q == SLOT_EMPTY) | REGCTL_A_rsp_ready);
      elig_b  = REGCTL_rst_n & REGCTL_B_valid & ((b_state_q == SLOT_EMPTY) | REGCTL_B_rsp_ready);
      grant_a = elig_a & (~elig_b | last_grant_q);
      grant_b = elig_b & (~elig_a | ~last_grant_q);
   end

   assign REGCTL_A_ready = grant_a;
   assign REGCTL_B_ready = grant_b;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      sel_we          = 1'b0;
      REGCTL_rf_addr1 = '0;
      REGCTL_rf_addr2 = '0;
      REGCTL_rf_waddr = '0;
      REGCTL_rf_wdata = '0;
      if (grant_a) begin
         sel_we          = REGCTL_A_we;
         REGCTL_rf_addr1 = REGCTL_A_addr1;
         REGCTL_rf_addr2 = REGCTL_A_addr2;
         REGCTL_rf_waddr = REGCTL_A_waddr;
         REGCTL_rf_wdata = REGCTL_A_wdata;
      end else if (grant_b) begin
         sel_we          = REGCTL_B_we;
         REGCTL_rf_addr1 = REGCTL_B_addr1;
         REGCTL_rf_addr2 = REGCTL_B_addr2;
         REGCTL_rf_waddr = REGCTL_B_waddr;
         REGCTL_rf_wdata = REGCTL_B_wdata;
      end
   end

   assign REGCTL_rf_we = (grant_a | grant_b) & sel_we & (REGCTL_rf_waddr != '0);

   // Register 0 reads as zero; a write acknowledge carries zero data.
   always_comb begin
      rsp_data1 = (sel_we || REGCTL_rf_addr1 == '0) ? '0 : REGCTL_rf_rdata1;
      rsp_data2 = (sel_we || REGCTL_rf_addr2 == '0) ? '0 : REGCTL_rf_rdata2;
   end

   // Next-state logic for both response slots and the tie-break pointer.
   always_comb begin
      a_state_d    = a_state_q;
      b_state_d    = b_state_q;
      a_data1_d    = a_data1_q;
      a_data2_d    = a_data2_q;
      b_data1_d    = b_data1_q;
      b_data2_d    = b_data2_q;
      last_grant_d = last_grant_q;

      if (grant_a) begin
         a_state_d    = SLOT_FULL;
         a_data1_d    = rsp_data1;
         a_data2_d    = rsp_data2;
         last_grant_d = 1'b0;
      end else if (a_state_q == SLOT_FULL && REGCTL_A_rsp_ready) begin
         a_state_d = SLOT_EMPTY;
      end

      if (grant_b) begin
         b_state_d    = SLOT_FULL;
         b_data1_d    = rsp_data1;
         b_data2_d    = rsp_data2;
         last_grant_d = 1'b1;
      end else if (b_state_q == SLOT_FULL && REGCTL_B_rsp_ready) begin
         b_state_d = SLOT_EMPTY;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge REGCTL_clk or negedge REGCTL_rst_n) begin
      if (!REGCTL_rst_n) begin
         a_state_q    <= SLOT_EMPTY;
         b_state_q    <= SLOT_EMPTY;
         a_data1_q    <= '0;
         a_data2_q    <= '0;
         b_data1_q    <= '0;
         b_data2_q    <= '0;
         last_grant_q <= 1'b1;
      end else begin
         a_state_q    <= a_state_d;
         b_state_q    <= b_state_d;
         a_data1_q    <= a_data1_d;
         a_data2_q    <= a_data2_d;
         b_data1_q    <= b_data1_d;
         b_data2_q    <= b_data2_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      REGCTL_A_rsp_valid = (a_state_q == SLOT_FULL);
      REGCTL_B_rsp_valid = (b_state_q == SLOT_FULL);
      REGCTL_A_rsp_data1 = a_data1_q;
      REGCTL_A_rsp_data2 = a_data2_q;
      REGCTL_B_rsp_data1 = b_data1_q;
      REGCTL_B_rsp_data2 = b_data2_q;
   end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural register file.
// Register i powers up as 0xA000_0000 + i, so reads of register 0 must be forced to zero by the DUT.
module tb_reg_access_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk, rst_n;
   logic          a_valid, a_ready, a_we, a_rsp_valid, a_rsp_ready;
   logic [AW-1:0] a_addr1, a_addr2, a_waddr;
   logic [DW-1:0] a_wdata, a_rsp_data1, a_rsp_data2;
   logic          b_valid, b_ready, b_we, b_rsp_valid, b_rsp_ready;
   logic [AW-1:0] b_addr1, b_addr2, b_waddr;
   logic [DW-1:0] b_wdata, b_rsp_data1, b_rsp_data2;
   logic [AW-1:0] rf_addr1, rf_addr2, rf_waddr;
   logic          rf_we;
   logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;
   logic [DW-1:0] rf_mem [32];

   int n_tests = 0;
   int n_fail  = 0;

   reg_access_ctrl #(.DW(DW), .AW(AW)) dut (
      .REGCTL_clk(clk), .REGCTL_rst_n(rst_n),
      .REGCTL_A_valid(a_valid), .REGCTL_A_ready(a_ready), .REGCTL_A_we(a_we),
      .REGCTL_A_addr1(a_addr1), .REGCTL_A_addr2(a_addr2),
      .REGCTL_A_waddr(a_waddr), .REGCTL_A_wdata(a_wdata),
      .REGCTL_A_rsp_valid(a_rsp_valid), .REGCTL_A_rsp_ready(a_rsp_ready),
      .REGCTL_A_rsp_data1(a_rsp_data1), .REGCTL_A_rsp_data2(a_rsp_data2),
      .REGCTL_B_valid(b_valid), .REGCTL_B_ready(b_ready), .REGCTL_B_we(b_we),
      .REGCTL_B_addr1(b_addr1), .REGCTL_B_addr2(b_addr2),
      .REGCTL_B_waddr(b_waddr), .REGCTL_B_wdata(b_wdata),
      .REGCTL_B_rsp_valid(b_rsp_valid), .REGCTL_B_rsp_ready(b_rsp_ready),
      .REGCTL_B_rsp_data1(b_rsp_data1), .REGCTL_B_rsp_data2(b_rsp_data2),
      .REGCTL_rf_addr1(rf_addr1), .REGCTL_rf_addr2(rf_addr2), .REGCTL_rf_waddr(rf_waddr),
      .REGCTL_rf_we(rf_we), .REGCTL_rf_wdata(rf_wdata),
      .REGCTL_rf_rdata1(rf_rdata1), .REGCTL_rf_rdata2(rf_rdata2)
   );

   always #5 clk = ~clk;

   // Register file: combinational read, write on the rising edge, pattern reload while in reset.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA000_0000 + i;
      end else if (rf_we) begin
         rf_mem[rf_waddr] <= rf_wdata;
      end
   end
   assign rf_rdata1 = rf_mem[rf_addr1];
   assign rf_rdata2 = rf_mem[rf_addr2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_a(input logic v, input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic rr);
      a_valid = v; a_we = we; a_addr1 = a1; a_addr2 = a2; a_waddr = wa; a_wdata = wd; a_rsp_ready = rr;
   endtask

   task automatic drive_b(input logic v, input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic rr);
      b_valid = v; b_we = we; b_addr1 = a1; b_addr2 = a2; b_waddr = wa; b_wdata = wd; b_rsp_ready = rr;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      drive_a(0, 0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);

      // Reset holds ready and rf_we low even with live requests.
      @(negedge clk);
      drive_a(1, 0, 1, 2, 0, 0, 1);
      drive_b(1, 1, 0, 0, 3, 32'h1111, 1);
      #1;
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      check("rst_rf_we", rf_we, 0);
      check("rst_a_rsp_valid", a_rsp_valid, 0);
      check("rst_b_rsp_valid", b_rsp_valid, 0);
      drive_a(0, 0, 0, 0, 0, 0, 1);
      drive_b(0, 0, 0, 0, 0, 0, 1);
      rst_n = 1'b1;

      // Continuous tie: A, B, A, B.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_a(1, 0, 1, 2, 0, 0, 1);
         drive_b(1, 0, 3, 4, 0, 0, 1);
         #1;
         check("tie_a_ready", a_ready, (i % 2 == 0));
         check("tie_b_ready", b_ready, (i % 2 != 0));
         check("tie_rf_addr1", rf_addr1, (i % 2 == 0) ? 1 : 3);
         after_edge();
         if (i % 2 == 0) check("tie_a_data1", a_rsp_data1, 32'hA000_0001);
         else            check("tie_b_data2", b_rsp_data2, 32'hA000_0004);
      end

      // B stalls its response; A keeps being served and B's data stays put.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_a(1, 0, 5, 6, 0, 0, 1);
         drive_b(1, 0, 6, 7, 0, 0, 0);
         #1;
         check("stall_b_ready", b_ready, 0);
         check("stall_a_ready", a_ready, 1);
         after_edge();
         check("stall_b_valid", b_rsp_valid, 1);
         check("stall_b_data1", b_rsp_data1, 32'hA000_0003);
         check("stall_a_data1", a_rsp_data1, 32'hA000_0005);
      end
      @(negedge clk);
      drive_a(0, 0, 0, 0, 0, 0, 1);
      drive_b(1, 0, 6, 7, 0, 0, 1);
      #1;
      check("unstall_b_ready", b_ready, 1);
      after_edge();
      check("unstall_b_data1", b_rsp_data1, 32'hA000_0006);
      check("unstall_b_data2", b_rsp_data2, 32'hA000_0007);
      @(negedge clk);
      drive_b(0, 0, 0, 0, 0, 0, 1);
      #1;
      check("idle_rf_addr1", rf_addr1, 0);
      check("idle_a_ready", a_ready, 0);
      after_edge();
      check("drain_a_valid", a_rsp_valid, 0);
      check("drain_b_valid", b_rsp_valid, 0);

      // Write r5 then read it back on the next cycle.
      @(negedge clk);
      drive_a(1, 1, 0, 0, 5, 32'hDEAD_BEEF, 1);
      #1;
      check("wr_a_ready", a_ready, 1);
      check("wr_rf_we", rf_we, 1);
      check("wr_rf_waddr", rf_waddr, 5);
      check("wr_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
      after_edge();
      check("wr_ack_valid", a_rsp_valid, 1);
      check("wr_ack_data1", a_rsp_data1, 0);
      check("wr_ack_data2", a_rsp_data2, 0);
      @(negedge clk);
      drive_a(1, 0, 5, 0, 0, 0, 1);
      #1;
      check("rd_rf_we", rf_we, 0);
      after_edge();
      check("rd_valid", a_rsp_valid, 1);
      check("rd_data1", a_rsp_data1, 32'hDEAD_BEEF);
      check("rd_data2", a_rsp_data2, 0);

      // Write to r0 is acknowledged but never issued; r0 reads as zero.
      @(negedge clk);
      drive_a(1, 1, 0, 0, 0, 32'h1234, 1);
      #1;
      check("r0_wr_ready", a_ready, 1);
      check("r0_rf_we", rf_we, 0);
      after_edge();
      check("r0_ack_valid", a_rsp_valid, 1);
      check("r0_ack_data1", a_rsp_data1, 0);
      @(negedge clk);
      drive_a(1, 0, 0, 0, 0, 0, 1);
      after_edge();
      check("r0_rd_data1", a_rsp_data1, 0);
      check("r0_rd_data2", a_rsp_data2, 0);

      // Back-to-back reads: pop and refill on the same edge.
      @(negedge clk);
      drive_a(1, 0, 5, 1, 0, 0, 1);
      after_edge();
      check("b2b1_valid", a_rsp_valid, 1);
      check("b2b1_data1", a_rsp_data1, 32'hDEAD_BEEF);
      check("b2b1_data2", a_rsp_data2, 32'hA000_0001);
      @(negedge clk);
      drive_a(1, 0, 2, 3, 0, 0, 1);
      after_edge();
      check("b2b2_valid", a_rsp_valid, 1);
      check("b2b2_data1", a_rsp_data1, 32'hA000_0002);
      check("b2b2_data2", a_rsp_data2, 32'hA000_0003);

      // Reset with A's slot full and a B write in the middle of being granted.
      @(negedge clk);
      drive_a(0, 0, 0, 0, 0, 0, 0);
      drive_b(1, 1, 0, 0, 9, 32'h55, 1);
      #1;
      check("pre_rst_b_ready", b_ready, 1);
      check("pre_rst_rf_we", rf_we, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_a_valid", a_rsp_valid, 0);
      check("mid_rst_a_data1", a_rsp_data1, 0);
      check("mid_rst_a_data2", a_rsp_data2, 0);
      check("mid_rst_rf_we", rf_we, 0);
      check("mid_rst_b_ready", b_ready, 0);
      @(posedge clk);
      @(negedge clk);
      drive_a(1, 0, 1, 2, 0, 0, 1);
      drive_b(1, 0, 3, 4, 0, 0, 1);
      #1;
      check("held_rst_a_ready", a_ready, 0);
      rst_n = 1'b1;
      #1;
      check("post_rst_a_ready", a_ready, 1);
      check("post_rst_b_ready", b_ready, 0);
      after_edge();
      check("post_rst_a_valid", a_rsp_valid, 1);
      check("post_rst_a_data1", a_rsp_data1, 32'hA000_0001);
      check("post_rst_b_valid", b_rsp_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
